inst_prefetch: RTL and testbench

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/ipf_pkg.sv | 44 ++++
 rtl/inst_queue.sv | 71 +++++++
 rtl/inst_prefetch.sv | 120 ++++++++++++
 tb/tb_inst_prefetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : ipf_pkg                                                        |
// | Purpose   : Shared widths, instruction field positions, opcode constants   |
// |             and the queue entry type for the instruction prefetch block.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package ipf_pkg;

   localparam int INST_W  = 8;
   localparam int PC_W    = 8;
   localparam int ENTRY_W = INST_W + PC_W;

   // Instruction layout: op[7:6], Rd[5:3], Rs[2:0]
   localparam int OP_HI = 7;
   localparam int OP_LO = 6;
   localparam int RD_HI = 5;
   localparam int RD_LO = 3;
   localparam int RS_HI = 2;
   localparam int RS_LO = 0;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SHR = 2'b01;

   // One queue slot: fetch address alongside the fetched instruction word.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [1:0] inst_op(input logic [INST_W-1:0] inst);
      return inst[OP_HI:OP_LO];
   endfunction

   function automatic logic [2:0] inst_rd(input logic [INST_W-1:0] inst);
      return inst[RD_HI:RD_LO];
   endfunction

   function automatic logic [2:0] inst_rs(input logic [INST_W-1:0] inst);
      return inst[RS_HI:RS_LO];
   endfunction

endpackage : ipf_pkg
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : inst_queue                                                     |
// | Purpose   : Circular FIFO holding fetched {pc, inst} entries.              |
// | Ports     : clk, rst        - clock, synchronous active-high reset         |
// |             flush           - empty the queue this cycle (wins over all)   |
// |             push, push_data - write an entry at the tail                   |
// |             pop             - retire the head entry (ignored when empty)   |
// |             count           - current occupancy, 0..DEPTH                  |
// |             head_data       - head entry, all zeros when empty             |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             pop_eff;
   logic             push_eff;

   // DEPTH is a power of two, so pointers wrap naturally on overflow.
   assign pop_eff  = pop && (count_q != '0);
   assign push_eff = push && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_eff) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_eff, pop_eff})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; the head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (!rst && push_eff) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign count     = count_q;
   assign head_data = (count_q != '0) ? mem[rd_ptr] : '0;

endmodule : inst_queue
`default_nettype wire

// File: rtl/inst_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : inst_prefetch                                                  |
// | Purpose   : Instruction prefetcher. Issues sequential reads to a 1-cycle   |
// |             latency instruction memory, buffers responses in a queue and   |
// |             presents them to decode with a valid/ready handshake.          |
// |             A redirect flushes the queue and restarts fetch.               |
// | Ports     : clk, rst                   - clock, sync active-high reset     |
// |             redirect_valid/redirect_pc - flush and restart fetch           |
// |             imem_req/imem_addr         - memory read strobe and address    |
// |             imem_rdata                 - read data, one cycle after req    |
// |             out_valid/out_ready        - decode handshake                  |
// |             out_inst/out_pc            - head instruction and its address  |
// |             stall_cycles (optional)    - saturating decode stall counter   |
// | Config    : INST_PREFETCH_STALL_CNT_EN adds the stall_cycles output.       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module inst_prefetch
   import ipf_pkg::*;
#(
   parameter int              QDEPTH   = 4,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc
`ifdef INST_PREFETCH_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [PC_W-1:0] pc_q;
   logic            inflight_q;
   logic [PC_W-1:0] inflight_pc_q;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occupancy;
   logic            push;
   logic            pop;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;
   logic [ENTRY_W-1:0] head_bits;

   // Credit check: an outstanding read already owns a queue slot, so a
   // response can never arrive to a full queue.
   assign occupancy = count + CW'(inflight_q);
   assign imem_req  = !rst && !redirect_valid && (occupancy < CW'(QDEPTH));
   assign imem_addr = pc_q;

   // A response landing in a redirect cycle belongs to the old stream.
   assign push            = inflight_q && !redirect_valid && !rst;
   assign push_entry.pc   = inflight_pc_q;
   assign push_entry.inst = imem_rdata;

   // Decode still sees its handshake complete during a redirect; the
   // flush empties the queue regardless.
   assign pop = out_valid && out_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q       <= redirect_pc;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            inflight_pc_q <= pc_q;
            pc_q          <= pc_q + 1'b1;
         end
      end
   end

   inst_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .count     (count),
      .head_data (head_bits)
   );

   assign head_entry = head_bits;
   assign out_valid  = (count != '0);
   assign out_inst   = head_entry.inst;
   assign out_pc     = head_entry.pc;

`ifdef INST_PREFETCH_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule : inst_prefetch
`default_nettype wire

// File: tb/tb_inst_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_inst_prefetch                                               |
// | Purpose   : Self-checking bench for inst_prefetch. A queue-based reference |
// |             model predicts every cycle; a monitor matches each delivered   |
// |             instruction against a scoreboard of expected deliveries.       |
// | Config    : INST_PREFETCH_STALL_CNT_EN also checks stall_cycles.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_inst_prefetch;

   localparam int         QDEPTH   = 4;
   localparam logic [7:0] RESET_PC = 8'h00;

   logic       clk = 1'b0;
   logic       rst;
   logic       redirect_valid;
   logic [7:0] redirect_pc;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_inst;
   logic [7:0] out_pc;
`ifdef INST_PREFETCH_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   inst_prefetch #(
      .QDEPTH   (QDEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
`ifdef INST_PREFETCH_STALL_CNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   typedef struct packed {
      logic [7:0] pc;
      logic [7:0] inst;
   } pair_t;

   int checks = 0;
   int errors = 0;

   // Reference model: fetch PC, one outstanding read, queue of fetched pairs.
   pair_t       m_q[$];
   pair_t       exp_q[$];
   logic [7:0]  m_pc = RESET_PC;
   bit          m_inflight = 1'b0;
   logic [7:0]  m_inflight_pc = 8'h00;
   int unsigned m_stall = 0;
   bit          m_known = 1'b0;

   // DUT outputs sampled during the most recent step
   bit         s_req, s_valid;
   logic [7:0] s_addr, s_inst, s_pc;

   function automatic logic [7:0] mem_rd(input logic [7:0] a);
      return a ^ 8'hA5;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock cycle: apply inputs, compare against the model, advance both.
   task automatic step(input bit r, input bit rv, input logic [7:0] rpc, input bit rdy);
      bit         e_req, e_valid;
      logic [7:0] e_pc, e_inst;
      pair_t      ent;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      e_valid = (m_q.size() != 0);
      e_req   = !r && !rv && ((m_q.size() + (m_inflight ? 1 : 0)) < QDEPTH);
      e_pc    = e_valid ? m_q[0].pc   : 8'h00;
      e_inst  = e_valid ? m_q[0].inst : 8'h00;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = out_valid;
      s_inst  = out_inst;
      s_pc    = out_pc;
      if (m_known) begin
         chk("imem_req", {31'd0, s_req}, {31'd0, e_req});
         if (e_req) chk("imem_addr", {24'd0, s_addr}, {24'd0, m_pc});
         chk("out_valid", {31'd0, s_valid}, {31'd0, e_valid});
         chk("out_pc", {24'd0, s_pc}, {24'd0, e_pc});
         chk("out_inst", {24'd0, s_inst}, {24'd0, e_inst});
`ifdef INST_PREFETCH_STALL_CNT_EN
         chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
`endif
         if (!r && e_valid && rdy) exp_q.push_back(m_q[0]);
      end
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_pc       = RESET_PC;
         m_inflight = 1'b0;
         m_stall    = 0;
         m_known    = 1'b1;
      end else begin
         if (e_valid && !rdy && m_stall < 65535) m_stall++;
         if (rv) begin
            m_q.delete();
            m_pc       = rpc;
            m_inflight = 1'b0;
         end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_inflight) begin
               ent.pc   = m_inflight_pc;
               ent.inst = mem_rd(m_inflight_pc);
               m_q.push_back(ent);
            end
            m_inflight = e_req;
            if (e_req) begin
               m_inflight_pc = m_pc;
               m_pc          = m_pc + 8'd1;
            end
         end
      end
      // Instruction memory: data for the address requested in the last cycle
      #1 imem_rdata = s_req ? mem_rd(s_addr) : 8'h00;
      @(negedge clk);
   endtask

   // Monitor: every decode handshake must match the next expected delivery.
   always @(posedge clk) begin
      pair_t e;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected actual pc=%h inst=%h required none", out_pc, out_inst);
         end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_inst !== e.inst) begin
               errors++;
               $display("FAIL deliver actual pc=%h inst=%h required pc=%h inst=%h",
                        out_pc, out_inst, e.pc, e.inst);
            end
         end
      end
   end

   initial begin
      int         reqs;
      logic [7:0] v;
      logic [7:0] got[$];
      int         mode;
      bit         r, rv, rdy;

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
      out_ready = 1'b0; imem_rdata = 8'h00;
      @(negedge clk);

      // Reset state
      step(1, 0, 8'h00, 1);
      step(1, 0, 8'h00, 1);
      chk("rst_imem_req", {31'd0, s_req}, 32'd0);
      chk("rst_out_valid", {31'd0, s_valid}, 32'd0);
      chk("rst_out_inst", {24'd0, s_inst}, 32'h00);
      chk("rst_out_pc", {24'd0, s_pc}, 32'h00);

      // First fetch latency and back-to-back delivery
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 1);
         if (i < 2) begin
            chk("start_req", {31'd0, s_req}, 32'd1);
            chk("start_addr", {24'd0, s_addr}, i);
            chk("start_valid", {31'd0, s_valid}, 32'd0);
         end else begin
            v = 8'(i - 2);
            chk("start_deliver_valid", {31'd0, s_valid}, 32'd1);
            chk("start_deliver_pc", {24'd0, s_pc}, {24'd0, v});
            chk("start_deliver_inst", {24'd0, s_inst}, {24'd0, v ^ 8'hA5});
         end
      end

      // Decode stalled: queue fills, fetch stops, head holds
      step(1, 0, 8'h00, 0);
      reqs = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 8'h00, 0);
         if (s_req) begin
            chk("stall_req_addr", {24'd0, s_addr}, reqs);
            reqs++;
         end
         if (i >= 2) chk("stall_head", {16'd0, s_pc, s_inst}, 32'h00A5);
      end
      chk("stall_req_count", reqs, 4);
      chk("stall_req_off", {31'd0, s_req}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 1);
`ifdef INST_PREFETCH_STALL_CNT_EN
         if (i == 0) chk("stall_count_10", {16'd0, stall_cycles}, 32'd10);
`endif
         v = 8'(i);
         chk("release_valid", {31'd0, s_valid}, 32'd1);
         chk("release_pc", {24'd0, s_pc}, {24'd0, v});
         chk("release_inst", {24'd0, s_inst}, {24'd0, v ^ 8'hA5});
      end

      // Redirect with three queued entries and one read outstanding
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0);
      step(0, 1, 8'h40, 0);
      chk("redir_req_suppressed", {31'd0, s_req}, 32'd0);
      chk("redir_had_entries", {31'd0, s_valid}, 32'd1);
      step(0, 0, 8'h00, 1);
      chk("redir_flushed", {31'd0, s_valid}, 32'd0);
      chk("redir_req", {31'd0, s_req}, 32'd1);
      chk("redir_addr", {24'd0, s_addr}, 32'h40);
      step(0, 0, 8'h00, 1);
      chk("redir_still_empty", {31'd0, s_valid}, 32'd0);
      step(0, 0, 8'h00, 1);
      chk("redir_first", {16'd0, s_pc, s_inst}, 32'h40E5);

      // PC wrap across 8'hFF
      step(0, 1, 8'hFE, 1);
      got.delete();
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 8'h00, 1);
         if (s_valid) got.push_back(s_pc);
      end
      chk("wrap_count_ok", {31'd0, got.size() >= 4}, 32'd1);
      if (got.size() >= 4) begin
         chk("wrap_pc0", {24'd0, got[0]}, 32'hFE);
         chk("wrap_pc1", {24'd0, got[1]}, 32'hFF);
         chk("wrap_pc2", {24'd0, got[2]}, 32'h00);
         chk("wrap_pc3", {24'd0, got[3]}, 32'h01);
      end

      // Reset mid-stream with two entries queued
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
      step(1, 0, 8'h00, 0);
      chk("midrst_had_entries", {31'd0, s_valid}, 32'd1);
      step(0, 0, 8'h00, 1);
      chk("midrst_flushed", {31'd0, s_valid}, 32'd0);
      chk("midrst_req_addr", {23'd0, s_req, s_addr}, 32'h100);
`ifdef INST_PREFETCH_STALL_CNT_EN
      chk("midrst_stall_zero", {16'd0, stall_cycles}, 32'd0);
`endif
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      chk("midrst_restart", {15'd0, s_valid, s_pc, s_inst}, 32'h100A5);

      // Randomized traffic in phases of differing decode pressure
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) mode = int'($urandom_range(0, 2));
         r   = ($urandom_range(0, 299) == 0);
         rv  = ($urandom_range(0, 39) == 0);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 3) == 0);
            default: rdy = ($urandom_range(0, 1) == 0);
         endcase
         step(r, rv, 8'($urandom), rdy);
      end

      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_inst_prefetch
`default_nettype wire
